// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter that locks a grant for a whole
// multi-beat transaction. The rotating priority pointer lives inside the
// block and only moves when a transaction ends, so fairness is counted in
// transactions rather than beats.
module rr_lock_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16,
    localparam int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    last,
    input  logic            ready,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            beat
);

    // A limit of 0 means unlimited, but the counter still needs one bit.
    localparam int CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [N-1:0]      ptr;
    logic [CNT_W-1:0]  cnt;

    logic              owner_req;
    logic              owner_last;
    logic              limit_hit;
    logic              end_evt;
    logic [N-1:0]      rot;
    logic [N-1:0]      arb_ptr;
    logic [N-1:0]      win;
    logic [ID_W-1:0]   win_id;

    // First asserted request at or above the one-hot pointer, wrapping round.
    function automatic logic [N-1:0] arbitrate(input logic [N-1:0] p,
                                               input logic [N-1:0] req);
        logic [N-1:0] res;
        int           base;
        int           idx;
        logic         found;
        res   = '0;
        base  = 0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                base = i;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                res[idx[ID_W-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner_req  = |(grant & request);
    assign owner_last = |(grant & last);
    assign beat       = grant_valid & ready & owner_req;
    assign limit_hit  = (MAX_BEATS != 0) && (int'(cnt) + 1 == MAX_BEATS);
    assign end_evt    = (state == BUSY) &&
                        (!owner_req || (beat && (owner_last || limit_hit)));

    // Rotating the ending grant gives its owner the lowest priority next.
    assign rot     = {grant[N-2:0], grant[N-1]};
    assign arb_ptr = end_evt ? rot : ptr;
    assign win     = arbitrate(arb_ptr, request);

    // Binary index of the winning requester for the registered grant_id.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Grant FSM: take a winner from idle, hold it until an end event, then
    // hand straight over to the next winner or fall back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= N'(1);
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request != '0) begin
                        grant       <= win;
                        grant_valid <= 1'b1;
                        grant_id    <= win_id;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (end_evt) begin
                        ptr <= rot;
                        cnt <= '0;
                        if (win != '0) begin
                            grant       <= win;
                            grant_valid <= 1'b1;
                            grant_id    <= win_id;
                        end else begin
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                            state       <= IDLE;
                        end
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
